// File: rtl/axi_stream_remove_header.sv
// Strips 0..DATA_BYTE_WD leading bytes per AXI-Stream packet and re-packs the rest; header capture under AXIS_REMOVE_HDR_CAPTURE_EN.
// Latency: one registered stage (first output after the second accepted beat, or after the first when nothing is stripped).
// Backpressure: s_axis_tready follows the free output register and is held low while the FLUSH tail beat is emitted.
module axi_stream_remove_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CNT_WD-1:0]       strip_bytes,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WD-1:0]      s_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [DATA_WD-1:0]      m_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    drop_pulse,
    output logic [DATA_WD-1:0]      hdr_data,
    output logic                    hdr_valid
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam logic [CNT_WD-1:0] BYTES = CNT_WD'(DATA_BYTE_WD);

    state_t                  state, state_nxt;
    logic [DATA_WD-1:0]      res_buf, res_buf_nxt;
    logic [CNT_WD-1:0]       res_cnt, res_cnt_nxt;
    logic [CNT_WD-1:0]       s_clamp, k_cnt;
    logic [CNT_WD:0]         sum_rk;
    logic [DATA_WD-1:0]      din_m;
    logic                    in_xfer, out_free, load, drop_nxt;
    logic [DATA_WD-1:0]      ld_dat;
    logic [DATA_BYTE_WD-1:0] ld_keep;
    logic                    ld_last;

    function automatic logic [DATA_BYTE_WD-1:0] top_ones(input logic [CNT_WD:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = rst_n && (state != FLUSH) && out_free;
    assign in_xfer       = s_axis_tvalid && s_axis_tready;
    assign s_clamp       = (strip_bytes > BYTES) ? BYTES : strip_bytes;
    assign sum_rk        = {1'b0, res_cnt} + {1'b0, k_cnt};

    // Unkept input bytes are zeroed so shifted paths produce zero padding.
    always_comb begin
        k_cnt = '0;
        din_m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k_cnt = k_cnt + CNT_WD'(s_axis_tkeep[DATA_BYTE_WD-1-i]);
            if (s_axis_tkeep[DATA_BYTE_WD-1-i])
                din_m[DATA_WD-1-8*i -: 8] = s_axis_tdata[DATA_WD-1-8*i -: 8];
        end
    end

    always_comb begin
        state_nxt   = state;
        res_buf_nxt = res_buf;
        res_cnt_nxt = res_cnt;
        load        = 1'b0;
        ld_dat      = m_axis_tdata;
        ld_keep     = m_axis_tkeep;
        ld_last     = m_axis_tlast;
        drop_nxt    = 1'b0;
        case (state)
            IDLE: if (in_xfer) begin
                if (s_clamp == '0) begin
                    load        = 1'b1;
                    ld_dat      = s_axis_tdata;
                    ld_keep     = s_axis_tkeep;
                    ld_last     = s_axis_tlast;
                    res_buf_nxt = '0;
                    res_cnt_nxt = '0;
                    state_nxt   = s_axis_tlast ? IDLE : STREAM;
                end else if (s_axis_tlast) begin
                    res_buf_nxt = '0;
                    res_cnt_nxt = '0;
                    if (k_cnt <= s_clamp) begin
                        drop_nxt = 1'b1;
                    end else begin
                        load    = 1'b1;
                        ld_dat  = din_m << {s_clamp, 3'b000};
                        ld_keep = top_ones({1'b0, k_cnt - s_clamp});
                        ld_last = 1'b1;
                    end
                end else begin
                    res_buf_nxt = din_m << {s_clamp, 3'b000};
                    res_cnt_nxt = k_cnt - s_clamp;
                    state_nxt   = STREAM;
                end
            end
            STREAM: if (in_xfer) begin
                load = 1'b1;
                if (res_cnt == '0) begin
                    ld_dat  = s_axis_tdata;
                    ld_keep = s_axis_tkeep;
                    ld_last = s_axis_tlast;
                    if (s_axis_tlast)
                        state_nxt = IDLE;
                end else begin
                    ld_dat      = res_buf | (din_m >> {res_cnt, 3'b000});
                    ld_keep     = '1;
                    ld_last     = 1'b0;
                    res_buf_nxt = din_m << {BYTES - res_cnt, 3'b000};
                    if (s_axis_tlast) begin
                        if (sum_rk <= {1'b0, BYTES}) begin
                            ld_keep     = top_ones(sum_rk);
                            ld_last     = 1'b1;
                            res_buf_nxt = '0;
                            res_cnt_nxt = '0;
                            state_nxt   = IDLE;
                        end else begin
                            res_cnt_nxt = CNT_WD'(sum_rk - {1'b0, BYTES});
                            state_nxt   = FLUSH;
                        end
                    end
                end
            end
            FLUSH: if (out_free) begin
                load        = 1'b1;
                ld_dat      = res_buf;
                ld_keep     = top_ones({1'b0, res_cnt});
                ld_last     = 1'b1;
                res_buf_nxt = '0;
                res_cnt_nxt = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            res_buf       <= '0;
            res_cnt       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            drop_pulse    <= 1'b0;
        end else begin
            state      <= state_nxt;
            res_buf    <= res_buf_nxt;
            res_cnt    <= res_cnt_nxt;
            drop_pulse <= drop_nxt;
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ld_dat;
                m_axis_tkeep  <= ld_keep;
                m_axis_tlast  <= ld_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef AXIS_REMOVE_HDR_CAPTURE_EN
    logic first_beat;
    assign first_beat = (state == IDLE) && in_xfer;

    // Raw input bytes are captured, including any beyond tkeep on a short beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_data  <= '0;
            hdr_valid <= 1'b0;
        end else begin
            hdr_valid <= first_beat;
            if (first_beat)
                hdr_data <= s_axis_tdata & ~({DATA_WD{1'b1}} >> {s_clamp, 3'b000});
        end
    end
`else
    assign hdr_data  = '0;
    assign hdr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed and random-backpressure bench for axi_stream_remove_header.
module tb_axi_stream_remove_header;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  strip_bytes = '0;
    logic        s_axis_tvalid = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic [3:0]  s_axis_tkeep = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        drop_pulse;
    logic [31:0] hdr_data;
    logic        hdr_valid;

    int vec_cnt = 0;
    int err_cnt = 0;
    int drop_cnt = 0;
    int hdr_cnt = 0;
    logic        rnd_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [36:0] held;
    logic [36:0] out_q[$];
    logic [36:0] exp_q[$];
    logic [31:0] hdr_q[$];

    axi_stream_remove_header dut (
        .clk(clk), .rst_n(rst_n), .strip_bytes(strip_bytes),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .drop_pulse(drop_pulse), .hdr_data(hdr_data), .hdr_valid(hdr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: handshakes, stall stability, pulses.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_vld", {63'd0, m_axis_tvalid}, 64'd1);
                chk("stall_hold", {27'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdata}, {27'd0, held});
            end
            if (m_axis_tvalid && m_axis_tready)
                out_q.push_back({m_axis_tkeep, m_axis_tlast, m_axis_tdata});
            if (drop_pulse) drop_cnt++;
            if (hdr_valid) begin
                hdr_cnt++;
                hdr_q.push_back(hdr_data);
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held = {m_axis_tkeep, m_axis_tlast, m_axis_tdata};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_mode) m_axis_tready = 1'($urandom_range(0, 1));
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!s_axis_tready && n < 500);
        if (!s_axis_tready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_q.push_back({k, l, d});
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (out_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_beats"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk({tag, "_beat"}, {27'd0, out_q[i]}, {27'd0, exp_q[i]});
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int d0;
        logic [7:0]  b[16];
        logic [31:0] d;
        logic [3:0]  k;
        int len, st, s, nb, elen, exp_drop;

        #1;
        chk("rst_s_ready", {63'd0, s_axis_tready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_m_data", {27'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdata}, 64'd0);
        chk("rst_drop", {63'd0, drop_pulse}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // strip 2, tail fits in one beat
        strip_bytes = 3'd2;
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        exp_beat(32'hCCDD1122, 4'b1111, 1'b0);
        exp_beat(32'h33445566, 4'b1111, 1'b1);
        drain("s2_fit", 100);

        // strip 2, tail overflows into FLUSH
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1110, 1'b1);
        chk("flush_s_ready", {63'd0, s_axis_tready}, 64'd0);
        exp_beat(32'hCCDD1122, 4'b1111, 1'b0);
        exp_beat(32'h33445566, 4'b1111, 1'b0);
        exp_beat(32'h77000000, 4'b1000, 1'b1);
        drain("s2_flush", 100);

        // strip 0: pass-through, one-cycle latency
        strip_bytes = 3'd0;
        send_beat(32'h01020304, 4'b1111, 1'b0);
        chk("s0_lat_vld", {63'd0, m_axis_tvalid}, 64'd1);
        chk("s0_lat_dat", {32'd0, m_axis_tdata}, {32'd0, 32'h01020304});
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h090A0B00, 4'b1110, 1'b1);
        exp_beat(32'h01020304, 4'b1111, 1'b0);
        exp_beat(32'h05060708, 4'b1111, 1'b0);
        exp_beat(32'h090A0B00, 4'b1110, 1'b1);
        drain("s0", 100);

        // strip 4 and strip 7 (clamped): first beat removed, rest unshifted
        for (int t = 0; t < 2; t++) begin
            strip_bytes = (t == 0) ? 3'd4 : 3'd7;
            send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
            send_beat(32'h11223344, 4'b1111, 1'b0);
            send_beat(32'h55667700, 4'b1110, 1'b1);
            exp_beat(32'h11223344, 4'b1111, 1'b0);
            exp_beat(32'h55667700, 4'b1110, 1'b1);
            drain((t == 0) ? "s4" : "s7", 100);
        end

        // single short beat swallowed completely
        d0 = drop_cnt;
        strip_bytes = 3'd3;
        send_beat(32'hAABBCCDD, 4'b1100, 1'b1);
        drain("drop", 20);
        chk("drop_pulse", 64'(drop_cnt - d0), 64'd1);
`ifdef AXIS_REMOVE_HDR_CAPTURE_EN
        chk("hdr_cnt", 64'(hdr_q.size()), 64'd1);
        if (hdr_q.size() > 0) chk("hdr_data", {32'd0, hdr_q[hdr_q.size()-1]}, {32'd0, 32'hAABBCC00});
`else
        chk("hdr_valid_tied", 64'(hdr_cnt), 64'd0);
        chk("hdr_data_tied", {32'd0, hdr_data}, 64'd0);
`endif

        // single beat that survives the strip
        strip_bytes = 3'd1;
        send_beat(32'hAABBCCDD, 4'b1110, 1'b1);
        exp_beat(32'hBBCC0000, 4'b1100, 1'b1);
        drain("single", 20);

        // reset mid-packet with output stalled
        strip_bytes = 3'd2;
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        m_axis_tready = 1'b0;
        send_beat(32'h11223344, 4'b1111, 1'b0);
        chk("pre_rst_vld", {63'd0, m_axis_tvalid}, 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {63'd0, m_axis_tvalid}, 64'd0);
        chk("mid_rst_dat", {27'd0, m_axis_tkeep, m_axis_tlast, m_axis_tdata}, 64'd0);
        chk("mid_rst_s_ready", {63'd0, s_axis_tready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        out_q.delete();
        @(posedge clk);
        #1;
        strip_bytes = 3'd1;
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1111, 1'b1);
        exp_beat(32'hBBCCDD11, 4'b1111, 1'b0);
        exp_beat(32'h22334400, 4'b1110, 1'b1);
        drain("post_rst", 100);

        // random packets, random backpressure, strip changed mid-packet
        d0 = drop_cnt;
        exp_drop = 0;
        rnd_mode = 1'b1;
        for (int p = 0; p < 50; p++) begin
            len = $urandom_range(1, 14);
            st  = $urandom_range(0, 6);
            s   = (st > 4) ? 4 : st;
            for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
            elen = len - s;
            if (elen <= 0) exp_drop++;
            else begin
                nb = (elen + 3) / 4;
                for (int j = 0; j < nb; j++) begin
                    d = '0; k = '0;
                    for (int i = 0; i < 4; i++)
                        if (4*j + i < elen) begin
                            d[31-8*i -: 8] = b[s + 4*j + i];
                            k[3-i] = 1'b1;
                        end
                    exp_beat(d, k, j == nb - 1);
                end
            end
            strip_bytes = 3'(st);
            nb = (len + 3) / 4;
            for (int j = 0; j < nb; j++) begin
                d = '0; k = '0;
                for (int i = 0; i < 4; i++)
                    if (4*j + i < len) begin
                        d[31-8*i -: 8] = b[4*j + i];
                        k[3-i] = 1'b1;
                    end
                send_beat(d, k, j == nb - 1);
                strip_bytes = 3'($urandom_range(0, 7));
            end
        end
        drain("rnd", 3000);
        rnd_mode = 1'b0;
        m_axis_tready = 1'b1;
        chk("rnd_drops", 64'(drop_cnt - d0), 64'(exp_drop));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
